riscv_dmem_responder: RTL and testbench
=======================================

# riscv_dmem_responder

Data-memory responder for the single-cycle RISC-V core: the memory end of the core's MemWrite / Mem_WrAddr / Mem_WrData / ReadData interface. It holds a word-organised RAM, performs byte/half/word stores with byte enables and sign- or zero-extended loads selected by funct3. Optionally it decodes a small memory-mapped I/O window (cycle counter, GPIO register, store counter). It sits beside the core at top level; the core stays combinational-read, single-cycle.

## Interface
- DEPTH, 1024: RAM size in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of RAM word 0.
- MMIO_BASE, 32'hFFFF_0000: byte address of the MMIO window (only with DMEM_MMIO_EN).
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- MemWrite  input  1  store strobe for the current cycle.
- Mem_WrAddr  input  32  byte address for load and store.
- Mem_WrData  input  32  store data; the low bytes are used for sb/sh.
- mem_funct3  input  3  access type, driven from Instr[14:12].
- ReadData  output  32  load result, aligned and extended; combinational.
- gpio_out  output  8  GPIO register (constant 0 without DMEM_MMIO_EN).
- misalign_err  output  1  sticky misaligned-access flag.

## Operation
- Access types by funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores use 000 sb, 001 sh, 010 sw.
  - Other codes: no write, ReadData = 0.
- RAM index = (Mem_WrAddr − BASE_ADDR) >> 2. An address outside [BASE_ADDR, BASE_ADDR + 4·DEPTH) is unmapped.
- Store with MemWrite=1:
  - sb writes byte lane addr[1:0].
  - sh writes lanes {addr[1],0} and {addr[1],1}.
  - sw writes all four lanes.
  - Lanes not written keep their value.
- Load:
  - Select lane(s) from addr[1:0].
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
- Misaligned access (sh/lh/lhu with addr[0]=1, or sw/lw with addr[1:0]≠0):
  - Store is suppressed and ReadData = 0.
  - misalign_err sets on the next edge and stays set until reset.
  - It is set only by a store, or by a load while MemWrite=0 and funct3 is a load code.
- Unmapped address: store ignored, ReadData = 0, misalign_err unaffected.
- MMIO, word access only; byte/half accesses to the window read 0 and are ignored:
  - +0x0 CYCLE: 32-bit free-running counter; a write loads Mem_WrData.
  - +0x4 GPIO: a write loads Mem_WrData[7:0] into gpio_out; a read returns {24'b0, gpio_out}.
  - +0x8 STORES: counts accepted RAM stores (not suppressed, not MMIO); read-only, writes ignored.

## Timing
- Reads are combinational from the current address and RAM contents.
- A store to address A is visible to a load of A in the next cycle. A load in the same cycle returns the old data.
- CYCLE increments every edge and wraps FFFF_FFFF→0000_0000. A read returns the pre-increment value.
- Write to CYCLE in the same cycle as the increment: the write wins, and CYCLE equals the written value after the edge.
- STORES wraps at 2^32.
- Reset asserted (asynchronous, any time):
  - misalign_err=0, gpio_out=0, CYCLE=0, STORES=0.
  - RAM contents are not reset.
  - ReadData follows the combinational path.
  - A store coinciding with reset assertion is lost.
- Reset deassertion: CYCLE reads 0 before the first edge and 1 after it.

## Configuration
- DMEM_MMIO_EN defined: the MMIO window, CYCLE, GPIO and STORES registers exist as described.
- DMEM_MMIO_EN undefined:
  - The window is unmapped (reads 0, writes ignored).
  - gpio_out is tied to 0.
  - No counter flops are synthesised.

## Structure
- Shared package riscv_mem_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - MMIO offsets (MMIO_CYCLE=0x0, MMIO_GPIO=0x4, MMIO_STORES=0x8).
- Sub-module dmem_load_align: purely combinational lane select plus sign/zero extension from {word, addr[1:0], funct3}.
  - It is reused for the store-lane byte-enable generation.

## Test plan
- sw 0xDEADBEEF to 0x10, then lb/lbu/lh/lhu at 0x10–0x13:
  - lb@0x13 = FFFF_FFDE, lbu@0x13 = 0000_00DE.
  - lh@0x12 = FFFF_DEAD, lhu@0x10 = 0000_BEEF.
- sw 0x11223344 to 0x20, sb 0xAA to 0x21, sh 0x5566 to 0x22 → lw@0x20 = 5566_AA44; STORES = 3.
- sh to 0x31, lw from 0x22:
  - Both return/write nothing (ReadData = 0, RAM unchanged).
  - misalign_err = 1 after the first edge and stays 1.
  - Async reset_n pulse mid-cycle clears it immediately.
- Write to address BASE_ADDR + 4·DEPTH → no RAM word changes and ReadData = 0; with no MMIO, writes to MMIO_BASE are ignored.
- DMEM_MMIO_EN:
  - sw 0xFFFF_FFFE to CYCLE → reads FFFF_FFFE, then FFFF_FFFF, then 0000_0000 on consecutive cycles.
  - sw 0x1A5 to GPIO → gpio_out = 0xA5.
  - sb to GPIO → gpio_out unchanged.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 access codes and MMIO register offsets.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MMIO_CYCLE  = 4'h0;
  localparam logic [3:0] MMIO_GPIO   = 4'h4;
  localparam logic [3:0] MMIO_STORES = 4'h8;

  function automatic logic f3_is_load(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic f3_is_store(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational lane select with sign/zero extension; the same decode yields the store byte enables
// and the misalignment flag for the access.
module dmem_load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data,
  output logic [3:0]  o_be,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  // Misaligned or undefined accesses return zero and enable no lanes.
  always_comb begin
    o_data       = '0;
    o_be         = '0;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be   = 4'b0001 << i_addr_lo;
        o_data = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
      end
      F3_H, F3_HU: begin
        if (i_addr_lo[0]) begin
          o_misaligned = 1'b1;
        end else begin
          o_be   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_data = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
        end
      end
      F3_W: begin
        if (i_addr_lo != 2'b00) begin
          o_misaligned = 1'b1;
        end else begin
          o_be   = 4'b1111;
          o_data = i_word;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: word RAM with byte-enabled stores and extended loads, sticky misalign flag.
// Define DMEM_MMIO_EN to add the MMIO window (CYCLE, GPIO, STORES).
module riscv_dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  input  logic [2:0]  mem_funct3,
  output logic [31:0] ReadData,
  output logic [7:0]  gpio_out,
  output logic        misalign_err
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  logic [31:0] r_mem [DEPTH];
  logic        r_misalign;

  logic [31:0]      w_off;
  logic [IDX_W-1:0] w_idx;
  logic             w_in_mmio;
  logic             w_in_ram;
  logic [31:0]      w_ram_word;
  logic [31:0]      w_align_data;
  logic [3:0]       w_be;
  logic             w_misaligned;
  logic             w_is_load;
  logic             w_is_store;
  logic             w_ram_we;
  logic [31:0]      w_wdata;
  logic             w_mmio_mapped;
  logic             w_mmio_rd_valid;
  logic [31:0]      w_mmio_rdata;
  logic             w_misalign_set;

  // Subtraction wraps addresses below BASE_ADDR to large offsets, so one compare covers both bounds.
  assign w_off      = Mem_WrAddr - BASE_ADDR;
  assign w_idx      = w_off[IDX_W+1:2];
  assign w_in_mmio  = (Mem_WrAddr[31:4] == MMIO_BASE[31:4]) && (Mem_WrAddr[3:2] != 2'b11);
  assign w_in_ram   = (w_off < RAM_BYTES) && !w_in_mmio;
  assign w_ram_word = r_mem[w_idx];
  assign w_is_load  = f3_is_load(mem_funct3);
  assign w_is_store = f3_is_store(mem_funct3);

  dmem_load_align u_align (
    .i_word       (w_ram_word),
    .i_addr_lo    (Mem_WrAddr[1:0]),
    .i_funct3     (mem_funct3),
    .o_data       (w_align_data),
    .o_be         (w_be),
    .o_misaligned (w_misaligned)
  );

  always_comb begin
    w_wdata = Mem_WrData;
    case (mem_funct3)
      F3_B:    w_wdata = {4{Mem_WrData[7:0]}};
      F3_H:    w_wdata = {2{Mem_WrData[15:0]}};
      default: w_wdata = Mem_WrData;
    endcase
  end

  assign w_ram_we       = MemWrite && w_in_ram && w_is_store && !w_misaligned;
  assign w_misalign_set = w_misaligned && (w_in_ram || w_mmio_mapped) &&
                          (MemWrite ? w_is_store : w_is_load);

  // RAM contents survive reset; the reset branch only blocks a store coinciding with reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
    end else if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_misalign <= 1'b0;
    end else if (w_misalign_set) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign_err = r_misalign;

`ifdef DMEM_MMIO_EN
  logic [31:0] r_cycle;
  logic [31:0] r_stores;
  logic [7:0]  r_gpio;
  logic        w_mmio_word_acc;
  logic        w_mmio_wr;
  logic [3:0]  w_mmio_ofs;

  assign w_mmio_word_acc = w_in_mmio && (mem_funct3 == F3_W) && (Mem_WrAddr[1:0] == 2'b00);
  assign w_mmio_wr       = MemWrite && w_mmio_word_acc;
  assign w_mmio_ofs      = Mem_WrAddr[3:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle  <= '0;
      r_stores <= '0;
      r_gpio   <= '0;
    end else begin
      r_cycle <= (w_mmio_wr && (w_mmio_ofs == MMIO_CYCLE)) ? Mem_WrData : r_cycle + 32'd1;
      if (w_mmio_wr && (w_mmio_ofs == MMIO_GPIO)) r_gpio <= Mem_WrData[7:0];
      if (w_ram_we) r_stores <= r_stores + 32'd1;
    end
  end

  always_comb begin
    w_mmio_rdata = '0;
    case (w_mmio_ofs)
      MMIO_CYCLE:  w_mmio_rdata = r_cycle;
      MMIO_GPIO:   w_mmio_rdata = {24'b0, r_gpio};
      MMIO_STORES: w_mmio_rdata = r_stores;
      default:     w_mmio_rdata = '0;
    endcase
  end

  assign w_mmio_rd_valid = w_mmio_word_acc;
  assign w_mmio_mapped   = w_in_mmio;
  assign gpio_out        = r_gpio;
`else
  assign w_mmio_rdata    = '0;
  assign w_mmio_rd_valid = 1'b0;
  assign w_mmio_mapped   = 1'b0;
  assign gpio_out        = '0;
`endif

  always_comb begin
    ReadData = '0;
    if (w_in_ram) begin
      ReadData = w_align_data;
    end else if (w_mmio_rd_valid) begin
      ReadData = w_mmio_rdata;
    end
  end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed self-checking bench for riscv_dmem_responder; MMIO checks build when DMEM_MMIO_EN is defined.
module tb_riscv_dmem_responder;
  import riscv_mem_pkg::*;

  localparam logic [31:0] MMIO = 32'hFFFF_0000;

  logic        clk;
  logic        reset_n;
  logic        MemWrite;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [2:0]  mem_funct3;
  logic [31:0] ReadData;
  logic [7:0]  gpio_out;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_dmem_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .MemWrite     (MemWrite),
    .Mem_WrAddr   (Mem_WrAddr),
    .Mem_WrData   (Mem_WrData),
    .mem_funct3   (mem_funct3),
    .ReadData     (ReadData),
    .gpio_out     (gpio_out),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    @(negedge clk);
    Mem_WrAddr = a; Mem_WrData = d; mem_funct3 = f3; MemWrite = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [2:0] f3);
    @(negedge clk);
    MemWrite = 1'b0; Mem_WrAddr = a; mem_funct3 = f3;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; MemWrite = 1'b0; Mem_WrAddr = '0; Mem_WrData = '0; mem_funct3 = F3_W;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b exp 0", misalign_err); end
    n_tests++;
    if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL reset_gpio: got %h exp 00", gpio_out); end
`ifdef DMEM_MMIO_EN
    @(negedge clk);
    Mem_WrAddr = MMIO + 32'h0; mem_funct3 = F3_W; reset_n = 1'b1;
    #1;
    n_tests++;
    if (ReadData !== 32'h0) begin n_fail++; $display("FAIL cycle_pre_edge: got %h exp 00000000", ReadData); end
    @(posedge clk);
    #1;
    n_tests++;
    if (ReadData !== 32'h1) begin n_fail++; $display("FAIL cycle_post_edge: got %h exp 00000001", ReadData); end
`else
    @(negedge clk);
    reset_n = 1'b1;
`endif
  endtask

  task automatic test_load_ext();
    logic [31:0] addr_v [9];
    logic [2:0]  f3_v   [9];
    logic [31:0] exp_v  [9];
    addr_v = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h11, 32'h10, 32'h12, 32'h10};
    f3_v   = '{F3_B, F3_BU, F3_H, F3_HU, F3_B, F3_BU, F3_W, F3_B, 3'b011};
    exp_v  = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF, 32'hFFFF_FFEF,
               32'h0000_00BE, 32'hDEAD_BEEF, 32'hFFFF_FFAD, 32'h0000_0000};
    do_store(32'h10, 32'hDEAD_BEEF, F3_W);
    for (int i = 0; i < 9; i++) begin
      set_load(addr_v[i], f3_v[i]);
      n_tests++;
      if (ReadData !== exp_v[i]) begin
        n_fail++;
        $display("FAIL load_ext[%0d] addr %h f3 %b: got %h exp %h", i, addr_v[i], f3_v[i], ReadData, exp_v[i]);
      end
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    Mem_WrAddr = 32'h10; Mem_WrData = 32'h1234_5678; mem_funct3 = F3_W; MemWrite = 1'b1;
    #1;
    n_tests++;
    if (ReadData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL same_cycle_old: got %h exp deadbeef", ReadData); end
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    #1;
    n_tests++;
    if (ReadData !== 32'h1234_5678) begin n_fail++; $display("FAIL next_cycle_new: got %h exp 12345678", ReadData); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] s0;
    s0 = '0;
`ifdef DMEM_MMIO_EN
    set_load(MMIO + 32'h8, F3_W);
    s0 = ReadData;
`endif
    do_store(32'h20, 32'h1122_3344, F3_W);
    do_store(32'h21, 32'hFFFF_FFAA, F3_B);
    do_store(32'h22, 32'hFFFF_5566, F3_H);
    set_load(32'h20, F3_W);
    n_tests++;
    if (ReadData !== 32'h5566_AA44) begin n_fail++; $display("FAIL lanes_lw20: got %h exp 5566aa44", ReadData); end
    set_load(32'h22, F3_HU);
    n_tests++;
    if (ReadData !== 32'h0000_5566) begin n_fail++; $display("FAIL lanes_lhu22: got %h exp 00005566", ReadData); end
`ifdef DMEM_MMIO_EN
    set_load(MMIO + 32'h8, F3_W);
    n_tests++;
    if (ReadData - s0 !== 32'd3) begin n_fail++; $display("FAIL stores_count: got %0d exp 3", ReadData - s0); end
    do_store(MMIO + 32'h8, 32'h0000_1000, F3_W);
    set_load(MMIO + 32'h8, F3_W);
    n_tests++;
    if (ReadData - s0 !== 32'd3) begin n_fail++; $display("FAIL stores_ro: got %0d exp 3", ReadData - s0); end
`endif
  endtask

  task automatic test_misalign();
    do_store(32'h30, 32'hCAFE_F00D, F3_W);
    do_store(32'h40, 32'h0101_0101, F3_W);
    n_tests++;
    if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_pre: got %b exp 0", misalign_err); end
    @(negedge clk);
    Mem_WrAddr = 32'h31; Mem_WrData = 32'h0000_BEEF; mem_funct3 = F3_H; MemWrite = 1'b1;
    #1;
    n_tests++;
    if (ReadData !== 32'h0) begin n_fail++; $display("FAIL misalign_sh_rd: got %h exp 00000000", ReadData); end
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    n_tests++;
    if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_set: got %b exp 1", misalign_err); end
    set_load(32'h30, F3_W);
    n_tests++;
    if (ReadData !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL misalign_ram_kept: got %h exp cafef00d", ReadData); end
    set_load(32'h22, F3_W);
    n_tests++;
    if (ReadData !== 32'h0) begin n_fail++; $display("FAIL misalign_lw: got %h exp 00000000", ReadData); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky: got %b exp 1", misalign_err); end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_async_clr: got %b exp 0", misalign_err); end
    @(negedge clk);
    Mem_WrAddr = 32'h40; Mem_WrData = 32'hDEAD_0000; mem_funct3 = F3_W; MemWrite = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    set_load(32'h40, F3_W);
    n_tests++;
    if (ReadData !== 32'h0101_0101) begin n_fail++; $display("FAIL store_in_reset_lost: got %h exp 01010101", ReadData); end
    set_load(32'h30, F3_W);
    n_tests++;
    if (ReadData !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ram_kept_reset: got %h exp cafef00d", ReadData); end
  endtask

  task automatic test_unmapped();
    do_store(32'h0, 32'h7777_7777, F3_W);
    do_store(32'hFFC, 32'h1357_9BDF, F3_W);
    do_store(32'h1000, 32'hFFFF_FFFF, F3_W);
    do_store(32'h1001, 32'hFFFF_FFFF, F3_W);
    n_tests++;
    if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL unmapped_no_misalign: got %b exp 0", misalign_err); end
    set_load(32'h0, F3_W);
    n_tests++;
    if (ReadData !== 32'h7777_7777) begin n_fail++; $display("FAIL unmapped_word0: got %h exp 77777777", ReadData); end
    set_load(32'hFFC, F3_W);
    n_tests++;
    if (ReadData !== 32'h1357_9BDF) begin n_fail++; $display("FAIL last_word: got %h exp 13579bdf", ReadData); end
    set_load(32'h1000, F3_W);
    n_tests++;
    if (ReadData !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd: got %h exp 00000000", ReadData); end
`ifndef DMEM_MMIO_EN
    do_store(MMIO + 32'h4, 32'h0000_01A5, F3_W);
    n_tests++;
    if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL nommio_gpio: got %h exp 00", gpio_out); end
    set_load(MMIO, F3_W);
    n_tests++;
    if (ReadData !== 32'h0) begin n_fail++; $display("FAIL nommio_rd: got %h exp 00000000", ReadData); end
`endif
  endtask

`ifdef DMEM_MMIO_EN
  task automatic test_mmio();
    logic [31:0] exp_c [3];
    exp_c = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    do_store(MMIO + 32'h0, 32'hFFFF_FFFE, F3_W);
    Mem_WrAddr = MMIO + 32'h0; mem_funct3 = F3_W;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      n_tests++;
      if (ReadData !== exp_c[i]) begin n_fail++; $display("FAIL cycle_wrap[%0d]: got %h exp %h", i, ReadData, exp_c[i]); end
    end
    do_store(MMIO + 32'h4, 32'h0000_01A5, F3_W);
    n_tests++;
    if (gpio_out !== 8'hA5) begin n_fail++; $display("FAIL gpio_sw: got %h exp a5", gpio_out); end
    set_load(MMIO + 32'h4, F3_W);
    n_tests++;
    if (ReadData !== 32'h0000_00A5) begin n_fail++; $display("FAIL gpio_rd: got %h exp 000000a5", ReadData); end
    do_store(MMIO + 32'h4, 32'h0000_0033, F3_B);
    n_tests++;
    if (gpio_out !== 8'hA5) begin n_fail++; $display("FAIL gpio_sb_ignored: got %h exp a5", gpio_out); end
    set_load(MMIO + 32'h4, F3_BU);
    n_tests++;
    if (ReadData !== 32'h0) begin n_fail++; $display("FAIL gpio_lbu_zero: got %h exp 00000000", ReadData); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_ext();
    test_same_cycle();
    test_byte_lanes();
    test_misalign();
    test_unmapped();
`ifdef DMEM_MMIO_EN
    test_mmio();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
